// File: rtl/alu_pkg.sv
// alu_pkg: constants and types shared between the issue stage, its decoder
// and the ALU side of the pipeline.
//   - ALU operation codes (4 bits) understood by the combinational ALU
//   - RISC-V major opcodes handled by the issue stage
//   - funct7 patterns that distinguish ADD/SUB and SRL/SRA
//   - issue_t: the decoded bundle held in the ID/EX register
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_XOR  = 4'b1100;
  localparam logic [3:0] ALU_SRL  = 4'b1101;
  localparam logic [3:0] ALU_SLL  = 4'b1110;
  localparam logic [3:0] ALU_SRA  = 4'b1111;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        reg_write;
    logic        illegal;
  } issue_t;

  // Maps funct3/funct7 of OP (is_reg=1) or OP-IMM (is_reg=0) to {legal, op}.
  // For OP-IMM, funct7 is part of the immediate except for the shifts.
  function automatic logic [4:0] funct_decode(input logic [2:0] funct3,
                                              input logic [6:0] funct7,
                                              input logic       is_reg);
    logic       legal;
    logic [3:0] op;
    legal = 1'b1;
    op    = ALU_ADD;
    case (funct3)
      3'b000: begin
        if (is_reg && (funct7 == F7_ALT)) begin
          op = ALU_SUB;
        end else if (is_reg && (funct7 != F7_BASE)) begin
          legal = 1'b0;
        end else begin
          op = ALU_ADD;
        end
      end
      3'b001: begin op = ALU_SLL;  legal = (funct7 == F7_BASE);            end
      3'b010: begin op = ALU_SLT;  legal = !is_reg || (funct7 == F7_BASE); end
      3'b011: begin op = ALU_SLTU; legal = !is_reg || (funct7 == F7_BASE); end
      3'b100: begin op = ALU_XOR;  legal = !is_reg || (funct7 == F7_BASE); end
      3'b110: begin op = ALU_OR;   legal = !is_reg || (funct7 == F7_BASE); end
      3'b111: begin op = ALU_AND;  legal = !is_reg || (funct7 == F7_BASE); end
      3'b101: begin
        if (funct7 == F7_ALT) begin
          op = ALU_SRA;
        end else if (funct7 == F7_BASE) begin
          op = ALU_SRL;
        end else begin
          legal = 1'b0;
        end
      end
      default: legal = 1'b0;
    endcase
    return {legal, op};
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: purely combinational decode of one instruction into ALU
// operands, operation code and writeback control.
//   instr_i     raw 32-bit instruction
//   pc_i        PC of the instruction (AUIPC operand A)
//   rs1_data_i  register-file read data for rs1
//   rs2_data_i  register-file read data for rs2
//   dec_o       decoded bundle (A, B, op, rd, reg_write, illegal)
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  output issue_t      dec_o
);

  logic [4:0]  fd;
  logic        is_shift;
  logic        legal;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] imm_i;
  logic [31:0] imm_u;

  // Decode opcode/funct fields and select operands; illegal forces A=B=0, ADD.
  always_comb begin
    // instr[5] separates OP (register form) from OP-IMM.
    fd       = funct_decode(instr_i[14:12], instr_i[31:25], instr_i[5]);
    // funct3 001 and 101 are the shifts; the ALU shifts by all of B, so mask.
    is_shift = (instr_i[13:12] == 2'b01);
    imm_i    = {{20{instr_i[31]}}, instr_i[31:20]};
    imm_u    = {instr_i[31:12], 12'h000};
    legal    = 1'b0;
    op       = ALU_ADD;
    a        = 32'h0000_0000;
    b        = 32'h0000_0000;
    case (instr_i[6:0])
      OPC_OP: begin
        legal = fd[4];
        op    = fd[3:0];
        a     = rs1_data_i;
        b     = is_shift ? {27'd0, rs2_data_i[4:0]} : rs2_data_i;
      end
      OPC_OP_IMM: begin
        legal = fd[4];
        op    = fd[3:0];
        a     = rs1_data_i;
        b     = is_shift ? {27'd0, instr_i[24:20]} : imm_i;
      end
      OPC_LUI: begin
        legal = 1'b1;
        b     = imm_u;
      end
      OPC_AUIPC: begin
        legal = 1'b1;
        a     = pc_i;
        b     = imm_u;
      end
      default: legal = 1'b0;
    endcase

    dec_o           = '0;
    dec_o.a         = legal ? a : 32'h0000_0000;
    dec_o.b         = legal ? b : 32'h0000_0000;
    dec_o.op        = legal ? op : ALU_ADD;
    dec_o.rd        = instr_i[11:7];
    dec_o.reg_write = legal && (instr_i[11:7] != 5'd0);
    dec_o.illegal   = !legal;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decode-and-issue stage feeding the combinational ALU.
// Holds one decoded instruction in the ID/EX register under valid/ready
// handshake, with flush (highest priority) and an accepted-instruction count.
//   clk, rstn                       clock, async active-low reset
//   id_valid/id_ready               upstream handshake
//   id_instr, id_pc, id_rs*_data    instruction and register-file data
//   flush                           drop held and incoming instruction
//   ex_valid/ex_ready               downstream handshake
//   ex_A, ex_B, ex_operation        ALU operands and operation
//   ex_rd, ex_reg_write, ex_illegal writeback control, decode error flag
//   issue_count                     accepted, non-flushed instructions (wraps)
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [31:0] id_instr,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic        flush,
  input  logic        ex_ready,
  output logic        ex_valid,
  output logic [31:0] ex_A,
  output logic [31:0] ex_B,
  output logic [3:0]  ex_operation,
  output logic [4:0]  ex_rd,
  output logic        ex_reg_write,
  output logic        ex_illegal,
  output logic [31:0] issue_count
);

  issue_t      dec;
  issue_t      ex_d;
  issue_t      ex_q;
  logic        ex_valid_d;
  logic        ex_valid_q;
  logic [31:0] count_d;
  logic [31:0] count_q;
  logic        accept;

  alu_op_decode u_decode (
    .instr_i    (id_instr),
    .pc_i       (id_pc),
    .rs1_data_i (id_rs1_data),
    .rs2_data_i (id_rs2_data),
    .dec_o      (dec)
  );

  assign id_ready = !ex_valid_q || ex_ready;
  assign accept   = id_valid && id_ready && !flush;

  // Next-state for the ID/EX register, valid bit and issue counter.
  always_comb begin
    ex_d       = ex_q;
    ex_valid_d = ex_valid_q;
    count_d    = count_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (accept) begin
      ex_valid_d = 1'b1;
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end else begin
      ex_valid_d = ex_valid_q;
    end
    if (accept) begin
      ex_d    = dec;
      count_d = count_q + 32'd1;
    end else begin
      ex_d    = ex_q;
      count_d = count_q;
    end
  end

  // ID/EX pipeline register and counter; reset clears every visible output.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
      count_q    <= 32'd0;
    end else begin
      ex_q       <= ex_d;
      ex_valid_q <= ex_valid_d;
      count_q    <= count_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_A         = ex_q.a;
  assign ex_B         = ex_q.b;
  assign ex_operation = ex_q.op;
  assign ex_rd        = ex_q.rd;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_illegal   = ex_q.illegal;
  assign issue_count  = count_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios from the
// feature list plus a randomized stream checked against an instruction-level
// reference model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rstn;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic        flush;
  logic        ex_ready;
  logic        ex_valid;
  logic [31:0] ex_A;
  logic [31:0] ex_B;
  logic [3:0]  ex_operation;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_illegal;
  logic [31:0] issue_count;

  int tests = 0;
  int fails = 0;
  logic [75:0] got;

  alu_issue_stage dut (
    .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .flush(flush), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ex_A(ex_A), .ex_B(ex_B), .ex_operation(ex_operation),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_illegal(ex_illegal),
    .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  // {valid, op, A, B, rd, reg_write, illegal}
  function automatic logic [75:0] snap();
    return {ex_valid, ex_operation, ex_A, ex_B, ex_rd, ex_reg_write, ex_illegal};
  endfunction

  // Same bundle with rd hidden when illegal (rd is unspecified then).
  function automatic logic [75:0] snap_masked();
    return {ex_valid, ex_operation, ex_A, ex_B,
            (ex_illegal ? 5'd0 : ex_rd), ex_reg_write, ex_illegal};
  endfunction

  // Reference: what the ALU must be told to do for one instruction.
  function automatic logic [75:0] model(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] r1, input logic [31:0] r2);
    logic [3:0]  tbl [0:7];
    logic [6:0]  opc;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    int          imm;
    bit ok, reg_form, shift, alt;
    tbl = '{4'b0010, 4'b1110, 4'b0111, 4'b1001, 4'b1100, 4'b1101, 4'b0001, 4'b0000};
    opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25]; rd = ins[11:7];
    ok = 1'b1; a = 32'd0; b = 32'd0; op = 4'b0010;
    if (opc == 7'h37) begin
      b = {ins[31:12], 12'h000};
    end else if (opc == 7'h17) begin
      a = pc;
      b = {ins[31:12], 12'h000};
    end else if (opc == 7'h33 || opc == 7'h13) begin
      reg_form = (opc == 7'h33);
      shift    = (f3 == 3'd1 || f3 == 3'd5);
      alt      = (f7 == 7'h20);
      ok = !(reg_form || shift) || (f7 == 7'h00) ||
           (alt && ((f3 == 3'd0 && reg_form) || f3 == 3'd5));
      op = tbl[f3];
      if (alt && f3 == 3'd0 && reg_form) op = 4'b0110;
      if (alt && f3 == 3'd5) op = 4'b1111;
      a = r1;
      imm = $signed(ins[31:20]);
      if (shift) b = reg_form ? (r2 % 32) : 32'(ins[24:20]);
      else       b = reg_form ? r2 : imm;
    end else begin
      ok = 1'b0;
    end
    if (!ok) begin a = 32'd0; b = 32'd0; op = 4'b0010; rd = 5'd0; end
    return {1'b1, op, a, b, rd, (ok && rd != 5'd0), !ok};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7, opc;
    logic [11:0] imm;
    rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
    rs1 = 5'($urandom); rs2 = 5'($urandom); f3 = 3'($urandom);
    imm = 12'($urandom);
    case ($urandom_range(0, 9))
      0, 1, 2: begin
        f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return {f7, rs2, rs1, f3, rd, 7'h33};
      end
      3, 4, 5: begin
        if (f3 == 3'd1) imm[11:5] = 7'h00;
        if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return {imm, rs1, f3, rd, 7'h13};
      end
      6: return {20'($urandom), rd, 7'h37};
      7: return {20'($urandom), rd, 7'h17};
      8: begin
        opc = 7'($urandom);
        if (opc == 7'h33 || opc == 7'h13 || opc == 7'h37 || opc == 7'h17) opc = 7'h7F;
        return {20'($urandom), rd, opc};
      end
      default: return {7'h01, rs2, rs1, 3'd0, rd, 7'h33};
    endcase
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic rdy, input logic fl);
    id_valid = v; id_instr = ins; id_pc = pc; id_rs1_data = r1; id_rs2_data = r2;
    ex_ready = rdy; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick(); tick();
    tests++;
    got = snap();
    if (got !== 76'd0) begin
      fails++; $display("FAIL reset_outputs got=%h exp=0", got);
    end
    tests++;
    if (id_ready !== 1'b1 || issue_count !== 32'd0) begin
      fails++; $display("FAIL reset_ready_count ready=%b count=%0d exp 1/0", id_ready, issue_count);
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_sub();
    drive(1'b1, {7'h20, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33}, 32'd0, 32'd10, 32'd3, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    tests++;
    got = snap();
    if (got !== {1'b1, 4'b0110, 32'd10, 32'd3, 5'd3, 1'b1, 1'b0}) begin
      fails++; $display("FAIL sub got=%h", got);
    end
    tests++;
    if (issue_count !== 32'd1) begin
      fails++; $display("FAIL sub_count got=%0d exp=1", issue_count);
    end
    tick();
    tests++;
    if (ex_valid !== 1'b0) begin
      fails++; $display("FAIL sub_drain ex_valid=%b exp=0", ex_valid);
    end
  endtask

  task automatic test_shifts();
    drive(1'b1, {7'h20, 5'd4, 5'd6, 3'd5, 5'd5, 7'h13}, 32'd0, 32'h8000_0000, 32'h1234_5678, 1'b1, 1'b0);
    tick();
    drive(1'b1, {7'h00, 5'd2, 5'd1, 3'd1, 5'd4, 7'h33}, 32'd0, 32'h0000_00F0, 32'hFFFF_FF21, 1'b1, 1'b0);
    tests++;
    got = snap();
    if (got !== {1'b1, 4'b1111, 32'h8000_0000, 32'd4, 5'd5, 1'b1, 1'b0}) begin
      fails++; $display("FAIL srai got=%h", got);
    end
    tick();
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    tests++;
    got = snap();
    if (got !== {1'b1, 4'b1110, 32'h0000_00F0, 32'd1, 5'd4, 1'b1, 1'b0}) begin
      fails++; $display("FAIL sll got=%h", got);
    end
    tick();
  endtask

  task automatic test_stall();
    drive(1'b1, {12'hFFF, 5'd0, 3'd0, 5'd1, 7'h13}, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tests++;
      got = snap();
      if (got !== {1'b1, 4'b0010, 32'd0, 32'hFFFF_FFFF, 5'd1, 1'b1, 1'b0} || id_ready !== 1'b0) begin
        fails++; $display("FAIL stall_hold cycle=%0d got=%h id_ready=%b", i, got, id_ready);
      end
      tests++;
      if (issue_count !== 32'd4) begin
        fails++; $display("FAIL stall_count got=%0d exp=4", issue_count);
      end
      tick();
    end
    ex_ready = 1'b1;
    tick();
    tests++;
    if (ex_valid !== 1'b0 || issue_count !== 32'd4) begin
      fails++; $display("FAIL stall_release ex_valid=%b count=%0d exp 0/4", ex_valid, issue_count);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, {20'hABCDE, 5'd7, 7'h37}, 32'd0, 32'h5555_5555, 32'd0, 1'b1, 1'b0);
    tick();
    drive(1'b1, {20'h12345, 5'd8, 7'h17}, 32'h100, 32'd0, 32'd0, 1'b1, 1'b0);
    tests++;
    got = snap();
    if (got !== {1'b1, 4'b0010, 32'd0, 32'hABCD_E000, 5'd7, 1'b1, 1'b0}) begin
      fails++; $display("FAIL b2b_lui got=%h", got);
    end
    tick();
    drive(1'b1, {7'h00, 5'd11, 5'd10, 3'd7, 5'd9, 7'h33}, 32'd0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b1, 1'b0);
    tests++;
    got = snap();
    if (got !== {1'b1, 4'b0010, 32'h100, 32'h1234_5000, 5'd8, 1'b1, 1'b0}) begin
      fails++; $display("FAIL b2b_auipc got=%h", got);
    end
    tick();
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    tests++;
    got = snap();
    if (got !== {1'b1, 4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd9, 1'b1, 1'b0} || issue_count !== 32'd7) begin
      fails++; $display("FAIL b2b_and got=%h count=%0d", got, issue_count);
    end
    tick();
  endtask

  task automatic test_flush_illegal();
    drive(1'b1, {7'h00, 5'd3, 5'd2, 3'd0, 5'd1, 7'h33}, 32'd0, 32'd5, 32'd6, 1'b0, 1'b0);
    tick();
    drive(1'b1, {7'h00, 5'd4, 5'd3, 3'd4, 5'd2, 7'h33}, 32'd0, 32'd1, 32'd2, 1'b0, 1'b1);
    tests++;
    if (ex_valid !== 1'b1 || issue_count !== 32'd8) begin
      fails++; $display("FAIL flush_pre ex_valid=%b count=%0d exp 1/8", ex_valid, issue_count);
    end
    tick();
    tests++;
    if (ex_valid !== 1'b0 || issue_count !== 32'd8) begin
      fails++; $display("FAIL flush ex_valid=%b count=%0d exp 0/8", ex_valid, issue_count);
    end
    drive(1'b1, 32'h0000_02FF, 32'h44, 32'd7, 32'd7, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    tests++;
    got = snap_masked();
    if (got !== {1'b1, 4'b0010, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1} || issue_count !== 32'd9) begin
      fails++; $display("FAIL illegal got=%h count=%0d", got, issue_count);
    end
    tick();
  endtask

  task automatic test_reset_midop();
    drive(1'b1, {12'h123, 5'd1, 3'd0, 5'd2, 7'h13}, 32'd0, 32'd9, 32'd0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    tests++;
    got = snap();
    if (got !== 76'd0 || issue_count !== 32'd0 || id_ready !== 1'b1) begin
      fails++; $display("FAIL reset_midop got=%h count=%0d ready=%b", got, issue_count, id_ready);
    end
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [75:0] exp_q = '0;
    bit          exp_v = 1'b0;
    logic [31:0] exp_cnt = 32'd0;
    bit          acc;
    bit          pending = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!pending) begin
        id_valid = ($urandom_range(0, 3) != 0);
        id_instr = rand_instr(); id_pc = $urandom;
        id_rs1_data = $urandom; id_rs2_data = $urandom;
      end
      ex_ready = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 9) == 0);
      #1;
      tests++;
      if (id_ready !== (!exp_v || ex_ready)) begin
        fails++; $display("FAIL rnd_id_ready cycle=%0d got=%b", c, id_ready);
      end
      acc = id_valid && (!exp_v || ex_ready) && !flush;
      if (acc) exp_q = model(id_instr, id_pc, id_rs1_data, id_rs2_data);
      if (flush) exp_v = 1'b0;
      else if (acc) exp_v = 1'b1;
      else if (ex_ready) exp_v = 1'b0;
      if (acc) exp_cnt = exp_cnt + 32'd1;
      pending = id_valid && !acc && !flush;
      tick();
      tests++;
      got = snap_masked();
      if (ex_valid !== exp_v || (exp_v && got !== exp_q)) begin
        fails++; $display("FAIL rnd_out cycle=%0d got=%h exp_v=%b exp=%h", c, got, exp_v, exp_q);
      end
      tests++;
      if (issue_count !== exp_cnt) begin
        fails++; $display("FAIL rnd_count cycle=%0d got=%0d exp=%0d", c, issue_count, exp_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sub();
    test_shifts();
    test_stall();
    test_back_to_back();
    test_flush_illegal();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
